pipelined_ripple_addsub: RTL and testbench

- Parametrised successor to the lab's 4-bit ripple-carry adder.
- WIDTH-bit add/subtract, carry chain split into SEG-bit ripple segments with one register stage per segment.
- Valid/ready handshake on input and output.
- Used in the datapath labs as the throughput-one adder between operand sources and accumulators.

---
 rtl/pipelined_ripple_addsub.sv | 126 ++++++++++++
 tb/tb_pipelined_ripple_addsub.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_addsub.sv
// Pipelined WIDTH-bit ripple-carry adder/subtractor.
// The carry chain is cut into SEG-bit segments, one register stage per
// segment. Operand bits not yet consumed and sum bits already produced
// travel alongside the carry in skew registers. A single global advance
// signal stalls the whole pipeline when the output is held.
module pipelined_ripple_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SEG;

  // Stage registers; index STAGES-1 is the output stage.
  logic             vld   [STAGES];
  logic [WIDTH-1:0] sum_r [STAGES];
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic             c_r   [STAGES];
  logic             ovf_r;

  // Next-state values for each stage.
  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic [WIDTH-1:0] nxt_a   [STAGES];
  logic [WIDTH-1:0] nxt_b   [STAGES];
  logic             nxt_c   [STAGES];
  logic             nxt_ovf;

  // Scratch values for the per-stage ripple.
  logic [WIDTH-1:0] ca;
  logic [WIDTH-1:0] cb;
  logic [WIDTH-1:0] cs;
  logic             cc;
  logic             cm;

  logic adv;

  assign adv       = ~vld[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[STAGES-1];
  assign s         = sum_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = ovf_r;

  // Each stage ripples its own SEG-bit slice; stage 0 works on the
  // prepared input operands, later stages on the skew registers.
  always_comb begin
    ca      = '0;
    cb      = '0;
    cs      = '0;
    cc      = 1'b0;
    cm      = 1'b0;
    nxt_ovf = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt_sum[k] = '0;
      nxt_a[k]   = '0;
      nxt_b[k]   = '0;
      nxt_c[k]   = 1'b0;
      if (k == 0) begin
        ca = x;
        cb = sub ? ~y : y;
        cc = sub ? 1'b1 : cin;
        cs = '0;
      end else begin
        ca = a_r[k-1];
        cb = b_r[k-1];
        cc = c_r[k-1];
        cs = sum_r[k-1];
      end
      for (int unsigned i = 0; i < SEG; i++) begin
        cm                 = cc;
        cs[k*SEG + i]      = ca[k*SEG + i] ^ cb[k*SEG + i] ^ cc;
        cc                 = (ca[k*SEG + i] & cb[k*SEG + i]) |
                             (cc & (ca[k*SEG + i] ^ cb[k*SEG + i]));
      end
      nxt_sum[k] = cs;
      nxt_a[k]   = ca;
      nxt_b[k]   = cb;
      nxt_c[k]   = cc;
      // cm holds the carry into the MSB once the last slice has rippled
      if (k == STAGES - 1) begin
        nxt_ovf = cm ^ cc;
      end
    end
  end

  // Pipeline advance: all stages move together or all hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k]   <= 1'b0;
        sum_r[k] <= '0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        c_r[k]   <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_r[k] <= nxt_sum[k];
        a_r[k]   <= nxt_a[k];
        b_r[k]   <= nxt_b[k];
        c_r[k]   <= nxt_c[k];
      end
      ovf_r <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_addsub.sv
// Self-checking bench for pipelined_ripple_addsub: directed vector table,
// streaming with backpressure, mid-stream reset and a parameter sweep.
module tb_pipelined_ripple_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int errors  = 0;
  int checks  = 0;
  int sw_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_ripple_addsub #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, s} from a wide sum and sign comparison.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic sb);
    logic [15:0] bb;
    logic [16:0] f;
    bb = sb ? ~b : b;
    f  = {1'b0, a} + {1'b0, bb} + {16'b0, (sb ? 1'b1 : c)};
    return {((a[15] == bb[15]) && (f[15] != a[15])), f};
  endfunction

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs [10];

  // One isolated beat: latency measured in edges after the accepting edge.
  task automatic apply(input string name, input logic [15:0] ax, input logic [15:0] ay,
                       input logic acin, input logic asub,
                       input logic [15:0] es, input logic ec, input logic eo);
    int cnt;
    x = ax; y = ay; cin = acin; sub = asub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = ~ax; y = ~ay;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({name, " latency"}, cnt, 3);
    check({name, " s"}, s, es);
    check({name, " cout"}, cout, ec);
    check({name, " ovf"}, ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] sx [20];
    logic [15:0] sy [20];
    logic        sc [20];
    logic        ss [20];
    logic [17:0] exp_q [$];
    logic [17:0] held_val;
    logic [17:0] e;
    logic        held;
    logic        exp_rdy;
    int          sent;
    int          got;
    int          extra;
    int          seen;
    int          guard;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset s", s, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub,
            vecs[i].es, vecs[i].ec, vecs[i].eo);
    end

    // Streaming with random backpressure
    for (int i = 0; i < 20; i++) begin
      sx[i] = 16'($urandom); sy[i] = 16'($urandom);
      sc[i] = 1'($urandom_range(0, 1)); ss[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; held = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      if (held) begin
        check("stall valid", out_valid, 1);
        check("stall hold", {ovf, cout, s}, held_val);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !out_valid || out_ready;
      check("stream in_ready", in_ready, exp_rdy);
      if (sent < 20) begin
        in_valid = 1'b1;
        if (exp_rdy) begin
          x = sx[sent]; y = sy[sent]; cin = sc[sent]; sub = ss[sent];
        end else begin
          x = 16'($urandom); y = 16'($urandom);
          cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("stream queue nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("stream beat%0d", got), {ovf, cout, s}, e);
        end
        got++;
      end
      held = out_valid && !out_ready;
      held_val = {ovf, cout, s};
      if (in_valid && exp_rdy) begin
        exp_q.push_back(model16(x, y, cin, sub));
        sent++;
      end
      @(posedge clk); #1;
    end
    check("stream received", got, 20);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("stream no extra beats", extra, 0);

    // Reset with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom);
      cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst s", s, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst no ghost beats", seen, 0);
    apply("post-reset", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);

    guard = 0;
    while (sw_done < 3 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    check("sweeps finished", sw_done, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Parameter sweep on independent instances, full throughput.
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W  = (g == 0) ? 4 : (g == 1) ? 8 : 32;
    localparam int SG = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    localparam int ST = W / SG;

    logic         srst;
    logic         iv;
    logic         ir;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic         ov;
    logic         orr;
    logic [W-1:0] so;
    logic         co;
    logic         of;

    pipelined_ripple_addsub #(.WIDTH(W), .SEG(SG)) dut (
      .clk(clk), .rst_n(srst), .in_valid(iv), .in_ready(ir),
      .x(a), .y(b), .cin(ci), .sub(sb), .out_valid(ov),
      .out_ready(orr), .s(so), .cout(co), .ovf(of)
    );

    initial begin
      logic [W+1:0] expv [100];
      logic [W:0]   full;
      logic [W-1:0] bb;
      srst = 1'b0; iv = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0; orr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      srst = 1'b1;
      for (int i = 0; i < 100 + ST + 1; i++) begin
        if (i < 100) begin
          a  = W'($urandom); b = W'($urandom);
          ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
          iv = 1'b1;
          bb = sb ? ~b : b;
          full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
          expv[i] = {((a[W-1] == bb[W-1]) && (full[W-1] != a[W-1])), full};
        end else begin
          iv = 1'b0;
        end
        @(posedge clk); #1;
        if (i >= ST - 1 && i - (ST - 1) < 100) begin
          check($sformatf("sweep W%0d valid", W), ov, 1);
          check($sformatf("sweep W%0d beat%0d", W, i - ST + 1), {of, co, so}, expv[i - ST + 1]);
        end else begin
          check($sformatf("sweep W%0d idle", W), ov, 0);
        end
      end
      sw_done++;
    end
  end

endmodule
